// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the instruction fetch port and the load/store port onto
// one single-port synchronous RAM. Data requests win, except when a pending
// fetch has lost STARVE_MAX consecutive grants to data traffic.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch channel
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store channel
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared RAM port
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RESP_I,
        RESP_D,
        RESP_W
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             grant_i;
    logic             grant_d;

    // Grant decision: only in IDLE, data first unless the fetch is starved
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (data_req && !(inst_req && (starve_cnt == STARVE_LIM))) begin
                grant_d = 1'b1;
            end else if (inst_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Starvation counter: counts data grants that bypass a pending fetch
    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_i) begin
            starve_nxt = '0;
        end else if (grant_d) begin
            if (!inst_req) begin
                starve_nxt = '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    // State and starvation counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next state, handshakes and RAM drive; RAM read data is forwarded in the RESP cycle
    always_comb begin
        state_nxt    = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        ram_en       = 1'b0;
        ram_we       = '0;
        ram_addr     = '0;
        ram_wdata    = '0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    data_addr_ok = 1'b1;
                    ram_en       = 1'b1;
                    ram_addr     = data_addr;
                    if (data_wr) begin
                        ram_we    = data_wstrb;
                        ram_wdata = data_wdata;
                        state_nxt = RESP_W;
                    end else begin
                        state_nxt = RESP_D;
                    end
                end else if (grant_i) begin
                    inst_addr_ok = 1'b1;
                    ram_en       = 1'b1;
                    ram_addr     = inst_addr;
                    state_nxt    = RESP_I;
                end
            end
            RESP_I: begin
                inst_data_ok = 1'b1;
                inst_rdata   = ram_rdata;
                state_nxt    = IDLE;
            end
            RESP_D: begin
                data_data_ok = 1'b1;
                data_rdata   = ram_rdata;
                state_nxt    = IDLE;
            end
            RESP_W: begin
                data_data_ok = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic; a per-cycle
// reference model predicts grants and pushes expected responses into a
// scoreboard queue that a monitor drains whenever a data_ok appears.
module tb_mem_arbiter;

    localparam int unsigned SMAX = 3;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_inst;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [4096];
    logic [31:0] ram_mem [4096];
    byte         hist_k[$];
    int          hist_c[$];
    bit          hist_on = 1'b0;
    int          cyc = 0;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)      return 32'h02800C0C;
        if (i == 'h400)  return 32'h11223344;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0;
        return base | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous single-port RAM: byte writes, read data one cycle after the access
    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = init_word(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                ram_rdata <= ram_mem[widx(ram_addr)];
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram_mem[widx(ram_addr)][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model and scoreboard monitor, evaluated mid-cycle
    initial begin
        int   due;
        int   starve;
        bit   g_i;
        bit   g_d;
        exp_t e;
        logic [31:0] w;
        due    = 0;
        starve = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
                check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
                due    = 0;
                starve = 0;
                exp_q.delete();
            end else begin
                check("inst_data_ok_timing", 32'(inst_data_ok), 32'(due == 1));
                check("data_data_ok_timing", 32'(data_data_ok), 32'(due == 2));
                if (inst_data_ok || data_data_ok) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got data_ok with empty scoreboard (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_channel", 32'(inst_data_ok), 32'(e.is_inst));
                        if (e.is_inst) check("inst_rdata", inst_rdata, e.rdata);
                        else           check("data_rdata", data_rdata, e.rdata);
                    end
                end
                if (due != 0) begin
                    check("resp_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
                    check("resp_data_addr_ok", 32'(data_addr_ok), 32'd0);
                    check("resp_ram_en", 32'(ram_en), 32'd0);
                    due = 0;
                end else begin
                    g_d = data_req && !(inst_req && starve == int'(SMAX));
                    g_i = inst_req && !g_d;
                    check("inst_addr_ok", 32'(inst_addr_ok), 32'(g_i));
                    check("data_addr_ok", 32'(data_addr_ok), 32'(g_d));
                    check("ram_en", 32'(ram_en), 32'(g_i | g_d));
                    if (g_d) begin
                        check("ram_addr_d", ram_addr, data_addr);
                        if (data_wr) begin
                            check("ram_we_store", 32'(ram_we), 32'(data_wstrb));
                            check("ram_wdata", ram_wdata, data_wdata);
                            w = ref_mem[widx(data_addr)];
                            for (int b = 0; b < 4; b++)
                                if (data_wstrb[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
                            ref_mem[widx(data_addr)] = w;
                            exp_q.push_back('{is_inst: 1'b0, rdata: 32'h0});
                        end else begin
                            check("ram_we_load", 32'(ram_we), 32'd0);
                            exp_q.push_back('{is_inst: 1'b0, rdata: ref_mem[widx(data_addr)]});
                        end
                        starve = inst_req ? ((starve < int'(SMAX)) ? starve + 1 : starve) : 0;
                        due = 2;
                    end else if (g_i) begin
                        check("ram_addr_i", ram_addr, inst_addr);
                        check("ram_we_fetch", 32'(ram_we), 32'd0);
                        exp_q.push_back('{is_inst: 1'b1, rdata: ref_mem[widx(inst_addr)]});
                        starve = 0;
                        due = 1;
                    end else begin
                        check("idle_ram_addr", ram_addr, 32'd0);
                        check("idle_ram_we", 32'(ram_we), 32'd0);
                        check("idle_ram_wdata", ram_wdata, 32'd0);
                    end
                end
            end
            if (hist_on && (inst_addr_ok || data_addr_ok)) begin
                hist_k.push_back(inst_addr_ok ? 8'd1 : 8'd2);
                hist_c.push_back(cyc);
            end
        end
    end

    // Keeps requests held until accepted, raising new ones with the given odds (percent)
    task automatic run_traffic(input int n, input int p_inst, input int p_data);
        logic ia;
        logic da;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ia = inst_addr_ok;
            da = data_addr_ok;
            @(posedge clk);
            #1;
            if (ia) inst_req = 1'b0;
            if (da) data_req = 1'b0;
            if (!inst_req && int'($urandom_range(0, 99)) < p_inst) begin
                inst_req  = 1'b1;
                inst_addr = rand_addr();
            end
            if (!data_req && int'($urandom_range(0, 99)) < p_data) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_wstrb = 4'($urandom_range(0, 15));
                data_addr  = rand_addr();
                data_wdata = $urandom();
            end
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios then randomized traffic
    initial begin
        reset      = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = '0;
        data_addr  = '0;
        data_wdata = '0;

        // reset state
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_ram_en", 32'(ram_en), 32'd0);
            check("reset_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            check("reset_inst_rdata", inst_rdata, 32'd0);
            check("reset_data_rdata", data_rdata, 32'd0);
        end
        next_drive();
        reset = 1'b0;

        // single fetch
        next_drive();
        inst_req  = 1'b1;
        inst_addr = 32'h1C000000;
        @(negedge clk);
        check("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("fetch_ram_en", 32'(ram_en), 32'd1);
        check("fetch_ram_we", 32'(ram_we), 32'd0);
        next_drive();
        inst_req = 1'b0;
        @(negedge clk);
        check("fetch_data_ok", 32'(inst_data_ok), 32'd1);
        check("fetch_rdata", inst_rdata, 32'h02800C0C);

        // partial store then load back
        next_drive();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'h3;
        data_addr  = 32'h1000;
        data_wdata = 32'hAABBCCDD;
        @(negedge clk);
        check("store_addr_ok", 32'(data_addr_ok), 32'd1);
        check("store_ram_we", 32'(ram_we), 32'h3);
        next_drive();
        data_req = 1'b0;
        @(negedge clk);
        check("store_data_ok", 32'(data_data_ok), 32'd1);
        next_drive();
        data_req = 1'b1;
        data_wr  = 1'b0;
        @(negedge clk);
        check("load_addr_ok", 32'(data_addr_ok), 32'd1);
        next_drive();
        data_req = 1'b0;
        @(negedge clk);
        check("load_data_ok", 32'(data_data_ok), 32'd1);
        check("load_rdata_merged", data_rdata, 32'h1122CCDD);

        // data request raised during a fetch response waits one cycle
        next_drive();
        inst_req = 1'b1;
        @(negedge clk);
        next_drive();
        inst_req = 1'b0;
        data_req = 1'b1;
        data_wr  = 1'b0;
        @(negedge clk);
        check("resp_i_blocks_data", 32'(data_addr_ok), 32'd0);
        next_drive();
        @(negedge clk);
        check("data_after_resp_i", 32'(data_addr_ok), 32'd1);
        next_drive();
        data_req = 1'b0;
        @(negedge clk);

        // reset during a load response drops the response
        next_drive();
        data_req  = 1'b1;
        data_addr = 32'h1000;
        @(negedge clk);
        check("pre_reset_load_ok", 32'(data_addr_ok), 32'd1);
        next_drive();
        data_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("reset_drops_data_ok", 32'(data_data_ok), 32'd0);
        next_drive();
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_no_data_ok", 32'(data_data_ok), 32'd0);
        next_drive();
        inst_req  = 1'b1;
        inst_addr = 32'h1C000000;
        @(negedge clk);
        check("post_reset_fetch_ok", 32'(inst_addr_ok), 32'd1);
        next_drive();
        inst_req = 1'b0;
        @(negedge clk);
        check("post_reset_fetch_data_ok", 32'(inst_data_ok), 32'd1);
        check("post_reset_fetch_rdata", inst_rdata, 32'h02800C0C);

        // both channels saturated: D,D,D,I pattern, one grant every two cycles
        hist_k.delete();
        hist_c.delete();
        hist_on = 1'b1;
        run_traffic(24, 100, 100);
        hist_on = 1'b0;
        run_traffic(6, 0, 0);
        check("starve_hist_len", 32'(hist_k.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < hist_k.size(); i++) begin
            check($sformatf("grant_seq_%0d", i), 32'(hist_k[i]), ((i % 4) == 3) ? 32'd1 : 32'd2);
            if (i > 0) check($sformatf("grant_gap_%0d", i), 32'(hist_c[i] - hist_c[i-1]), 32'd2);
        end

        // randomized mixed traffic, then drain
        run_traffic(800, 45, 60);
        run_traffic(8, 0, 0);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // quiet period
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("quiet_outputs",
                  32'({ram_en, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter that sits directly downstream of the CPU core's instruction and data memory ports. It merges the instruction fetch port (read-only) and the load/store port onto one shared single-port synchronous RAM, using a req/addr_ok/data_ok handshake on both CPU-side channels. Data-side requests have priority. A starvation counter guarantees instruction fetch forward progress under continuous load/store traffic.

## Interface
- `STARVE_MAX`, default 3: number of consecutive data grants with an instruction request pending, after which the instruction request is granted.
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `inst_req` in 1: fetch request valid.
- `inst_addr` in 32: fetch byte address, word-aligned.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch data returned this cycle.
- `inst_rdata` out 32: fetch data; valid only when `inst_data_ok`=1.
- `data_req` in 1: load/store request valid.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_wstrb` in 4: byte enables for a store.
- `data_addr` in 32: load/store byte address, word-aligned.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: load/store request accepted this cycle.
- `data_data_ok` out 1: load data returned or store completed this cycle.
- `data_rdata` out 32: load data; valid only when `data_data_ok`=1 for a load.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 4: RAM byte write enables.
- `ram_addr` out 32: RAM byte address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid one cycle after `ram_en` with `ram_we`=0.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - RESP_I: fetch response.
  - RESP_D: load response.
  - RESP_W: store completion.
- IDLE grant rule:
  - Only `data_req`: grant data.
  - Only `inst_req`: grant inst.
  - Both: grant data, unless `starve_cnt` == `STARVE_MAX`, in which case grant inst.
- On a grant in IDLE:
  - The granted `*_addr_ok` is 1 combinationally.
  - The RAM is driven combinationally in the same cycle: `ram_en`=1, `ram_addr` = granted addr.
  - For a store: `ram_we` = `data_wstrb` and `ram_wdata` = `data_wdata`. Otherwise `ram_we`=0.
  - Next state is RESP_I (fetch), RESP_D (load) or RESP_W (store).
- RESP_I: `inst_data_ok`=1 and `inst_rdata` = `ram_rdata`. Next state IDLE.
- RESP_D: `data_data_ok`=1 and `data_rdata` = `ram_rdata`. Next state IDLE.
- RESP_W: `data_data_ok`=1 and `data_rdata`=0. Next state IDLE.
- No request is accepted in a RESP state. Both `addr_ok` outputs are 0 and `ram_en`=0. Peak throughput is one access per 2 cycles.
- `starve_cnt` (2-bit minimum, saturating at `STARVE_MAX`):
  - +1 on a data grant while `inst_req`=1.
  - Cleared on any inst grant.
  - Cleared on a data grant while `inst_req`=0.
- The requester holds `req`/addr/wdata stable until `addr_ok`; the arbiter does not latch them.
- When nothing is granted in IDLE: `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.

## Timing
- Reset values: state=IDLE, `starve_cnt`=0, all `*_data_ok`=0, all `*_rdata`=0.
- RAM and `addr_ok` outputs after reset follow the IDLE rules above, i.e. 0 with no request.
- Latency: request accepted in cycle N gives `data_ok` in cycle N+1, for loads, fetches and stores alike.
- A request raised in a RESP cycle is accepted in the following IDLE cycle at the earliest.
- Simultaneous inst and data requests in IDLE: exactly one `addr_ok` asserts, never both.
- Reset asserted mid-transaction:
  - State returns to IDLE immediately and the pending `data_ok` is dropped.
  - The RAM write of an already-granted store stands.
- A fetch arriving while a data transaction is in RESP waits; it is not counted as starved until a data grant occurs while it pends.

## Test plan
- Reset, then a single fetch of 0x1C000000 with RAM word 0x02800C0C:
  - Cycle 0: `inst_addr_ok`=1, `ram_en`=1, `ram_we`=0.
  - Cycle 1: `inst_data_ok`=1, `inst_rdata`=0x02800C0C.
- Store `wstrb`=0x3 with wdata 0xAABBCCDD to 0x1000, then load 0x1000 (old word 0x11223344):
  - Store: `ram_we`=0x3, then `data_data_ok` on the next cycle.
  - Load: `data_rdata`=0x1122CCDD.
- `inst_req` and `data_req` both held high continuously, `STARVE_MAX`=3:
  - Grant sequence is D,D,D,I,D,D,D,I…
  - One `addr_ok` every 2 cycles.
- `data_req` asserted during RESP_I: no `data_addr_ok` that cycle; `data_addr_ok`=1 in the next cycle.
- `reset` pulsed in the cycle after a load grant: no `data_data_ok`; state IDLE; the next fetch completes normally with 1-cycle latency.
- No requests for 10 cycles: `ram_en`, both `addr_ok` and both `data_ok` stay 0 throughout.
